// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants for the instruction-memory responder.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } ifetch_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RANGE    = 2'd2
  } fetch_err_e;

  // Word index is taken from the full byte address, so high bits never wrap.
  function automatic fetch_err_e fetch_check(input logic [XLEN-1:0] addr,
                                             input int unsigned depth);
    if (addr[1:0] != 2'b00) return ERR_MISALIGN;
    if ({2'b00, addr[XLEN-1:2]} >= depth) return ERR_RANGE;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request/response channel between the IF stage (master) and instruction memory (slave).
interface imem_responder_if;
  import riscv_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/imem_array.sv
// Program-image word array: one synchronous write port, one registered read port.
module imem_array #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int          WIDTH       = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_waddr,
  input  logic [WIDTH-1:0]               i_wdata,
  input  logic                           i_re,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_raddr,
  output logic [WIDTH-1:0]               o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH_WORDS];
  logic [WIDTH-1:0] r_rdata;

  // The array itself is never reset so the program image survives a reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read-before-write: a same-edge write to the read address returns the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts fetch addresses, waits WAIT_STATES cycles,
// then presents the word (or NOP_WORD with rsp_err) until the IF stage takes it.
//
// state | meaning
// IDLE  | ready for a fetch address
// WAIT  | address latched, counting down wait states
// RESP  | response valid, held until rsp_ready; may accept the next fetch
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] NOP_WORD    = riscv_pkg::NOP_WORD
) (
  input  logic                           clk,
  input  logic                           reset,
  imem_responder_if.slave                bus,
  input  logic                           load_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
  input  logic [31:0]                    load_data
);
  import riscv_pkg::*;

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] WAIT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  ifetch_state_e   r_state;
  ifetch_state_e   w_state_nxt;
  logic [2:0]      r_cnt;
  logic [2:0]      w_cnt_nxt;
  logic            r_live;
  logic [XLEN-1:0] r_addr;
  logic            r_rsp_err;
  logic            w_take_req;
  logic            w_enter_resp;
  logic [XLEN-1:0] w_rd_addr;
  logic            w_rd_err;
  logic [XLEN-1:0] w_rdata;
  logic            w_load_we;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_take_req    = 1'b0;
    w_enter_resp  = 1'b0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        bus.req_ready = r_live;
        w_take_req    = r_live & bus.req_valid;
      end
      WAIT: begin
        if (r_cnt == 3'd0) begin
          w_state_nxt  = RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.req_ready = bus.rsp_ready;
        if (bus.rsp_ready) begin
          if (bus.req_valid) w_take_req  = 1'b1;
          else               w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_take_req) begin
      if (WAIT_STATES == 0) begin
        w_state_nxt  = RESP;
        w_enter_resp = 1'b1;
      end else begin
        w_state_nxt = WAIT;
        w_cnt_nxt   = WAIT_INIT;
      end
    end
  end

  // r_live keeps req_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_live    <= 1'b0;
      r_addr    <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_take_req)   r_addr    <= bus.req_addr;
      if (w_enter_resp) r_rsp_err <= w_rd_err;
    end
  end

  // With no wait states the array is read on the accepting edge, before r_addr is valid.
  assign w_rd_addr = (WAIT_STATES == 0) ? bus.req_addr : r_addr;
  assign w_rd_err  = (fetch_check(w_rd_addr, DEPTH_WORDS) != ERR_NONE);
  assign w_load_we = load_en & reset;

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .WIDTH       (XLEN)
  ) u_array (
    .clk     (clk),
    .rst_n   (reset),
    .i_we    (w_load_we),
    .i_waddr (load_addr),
    .i_wdata (load_data),
    .i_re    (w_enter_resp),
    .i_raddr (w_rd_addr[AW+1:2]),
    .o_rdata (w_rdata)
  );

  assign bus.rsp_data = r_rsp_err ? NOP_WORD : w_rdata;
  assign bus.rsp_err  = r_rsp_err;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: one WAIT_STATES=1 and one WAIT_STATES=0 instance,
// expected responses queued at request acceptance and compared at response handshake.
module tb_imem_responder;
  import riscv_pkg::*;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [31:0] load_data;

  always #5 clk = ~clk;

  imem_responder_if bus1();
  imem_responder_if bus0();

  imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) u_dut1 (
    .clk(clk), .reset(rst_n), .bus(bus1),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(rst_n), .bus(bus0),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [32:0] q1[$];
  logic [32:0] q0[$];
  int          rc1[$];
  int          rc0[$];
  logic [31:0] model [DEPTH];
  logic [32:0] e1, e0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] expect_rsp(input logic [31:0] addr);
    if (addr[1:0] != 2'b00 || addr >= 32'(DEPTH * 4)) return {1'b1, 32'h0000_0013};
    return {1'b0, model[addr[9:2]]};
  endfunction

  // Response monitors: every handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus1.rsp_valid && bus1.rsp_ready) begin
      check("rsp1_expected", 64'(q1.size() != 0), 64'd1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        check("rsp1_word", 64'({bus1.rsp_err, bus1.rsp_data}), 64'(e1));
        rc1.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (bus0.rsp_valid && bus0.rsp_ready) begin
      check("rsp0_expected", 64'(q0.size() != 0), 64'd1);
      if (q0.size() != 0) begin
        e0 = q0.pop_front();
        check("rsp0_word", 64'({bus0.rsp_err, bus0.rsp_data}), 64'(e0));
        rc0.push_back(cyc);
      end
    end
  end

  task automatic load_word(input int idx, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = 8'(idx);
    load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
    model[idx] = d;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input int which, input logic [31:0] addr, input bit push, output int acc);
    int   n = 0;
    logic rdy;
    if (which == 1) begin bus1.req_valid = 1'b1; bus1.req_addr = addr; end
    else            begin bus0.req_valid = 1'b1; bus0.req_addr = addr; end
    do begin
      @(negedge clk);
      n++;
      rdy = (which == 1) ? bus1.req_ready : bus0.req_ready;
    end while (!rdy && n < 20);
    check((which == 1) ? "accept1" : "accept0", 64'(rdy), 64'd1);
    acc = cyc;
    if (rdy && push) begin
      if (which == 1) q1.push_back(expect_rsp(addr));
      else            q0.push_back(expect_rsp(addr));
    end
    @(posedge clk); #1;
    if (which == 1) bus1.req_valid = 1'b0;
    else            bus0.req_valid = 1'b0;
  endtask

  task automatic drain(input int which);
    int n = 0;
    while (((which == 1) ? q1.size() : q0.size()) != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check((which == 1) ? "drain1" : "drain0", 64'((which == 1) ? q1.size() : q0.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_rsp_valid1();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus1.rsp_valid && n < 20);
    check("rsp_valid_seen", 64'(bus1.rsp_valid), 64'd1);
  endtask

  initial begin
    int a0, a;
    rst_n = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    bus1.req_valid = 1'b0; bus1.req_addr = '0; bus1.rsp_ready = 1'b1;
    bus0.req_valid = 1'b0; bus0.req_addr = '0; bus0.rsp_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready",  64'(bus1.req_ready), 64'd0);
    check("rst_rsp_valid",  64'(bus1.rsp_valid), 64'd0);
    check("rst_rsp_data",   64'(bus1.rsp_data),  64'd0);
    check("rst_rsp_err",    64'(bus1.rsp_err),   64'd0);
    check("rst_req_ready0", 64'(bus0.req_ready), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_release",  64'(bus1.req_ready), 64'd1);
    check("ready_after_release0", 64'(bus0.req_ready), 64'd1);

    load_word(0, 32'h0050_0093);
    load_word(1, 32'h0030_0113);
    load_word(2, 32'h0020_81B3);
    load_word(3, 32'h4020_8233);
    load_word(5, 32'h1111_1111);

    // Back-to-back fetches, one wait state.
    rc1.delete();
    issue(1, 32'h0, 1'b1, a0);
    issue(1, 32'h4, 1'b1, a);
    issue(1, 32'h8, 1'b1, a);
    issue(1, 32'hC, 1'b1, a);
    drain(1);
    check("rsp_count_ws1", 64'(rc1.size()), 64'd4);
    check("latency_ws1", 64'(rc1[0] - a0), 64'd2);
    for (int i = 1; i < 4; i++) check("period_ws1", 64'(rc1[i] - rc1[i-1]), 64'd2);

    // Backpressure.
    bus1.rsp_ready = 1'b0;
    issue(1, 32'h4, 1'b1, a);
    wait_rsp_valid1();
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", 64'({bus1.rsp_valid, bus1.req_ready, bus1.rsp_err, bus1.rsp_data}),
            64'({1'b1, 1'b0, 1'b0, 32'h0030_0113}));
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus1.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle", 64'({bus1.rsp_valid, bus1.req_ready}), 64'b01);
    check("bp_drained", 64'(q1.size()), 64'd0);

    // Error responses.
    issue(1, 32'h6,   1'b1, a);
    issue(1, 32'h400, 1'b1, a);
    issue(1, 32'h0,   1'b1, a);
    drain(1);

    // Load collides with the read edge of a fetch of word 2.
    issue(1, 32'h8, 1'b1, a);
    load_en = 1'b1; load_addr = 8'd2; load_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    load_en = 1'b0;
    model[2] = 32'hDEAD_BEEF;
    drain(1);
    issue(1, 32'h8, 1'b1, a);
    drain(1);

    // Reset while in WAIT; a load attempted during reset must be ignored.
    issue(1, 32'h0, 1'b0, a);
    #2 rst_n = 1'b0;
    #1 check("rst_in_wait", 64'({bus1.rsp_valid, bus1.req_ready}), 64'd0);
    load_en = 1'b1; load_addr = 8'd5; load_data = 32'h0000_0BAD;
    @(posedge clk); #1;
    load_en = 1'b0;
    check("rst_hold_data", 64'({bus1.rsp_err, bus1.rsp_data}), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_stale_wait", 64'(bus1.rsp_valid), 64'd0);
    end
    @(posedge clk); #1;
    check("ready_post_rst", 64'(bus1.req_ready), 64'd1);

    // Reset while a response is held in RESP.
    bus1.rsp_ready = 1'b0;
    issue(1, 32'h4, 1'b0, a);
    wait_rsp_valid1();
    #2 rst_n = 1'b0;
    #1 check("rst_in_resp", 64'({bus1.rsp_valid, bus1.req_ready, bus1.rsp_err}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus1.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_stale_resp", 64'(bus1.rsp_valid), 64'd0);
    end
    @(posedge clk); #1;
    issue(1, 32'h0,  1'b1, a);
    issue(1, 32'h14, 1'b1, a);
    drain(1);

    // Zero wait states: single-cycle latency and one word per cycle.
    rc0.delete();
    issue(0, 32'h0, 1'b1, a0);
    issue(0, 32'h4, 1'b1, a);
    issue(0, 32'h8, 1'b1, a);
    issue(0, 32'hC, 1'b1, a);
    drain(0);
    check("rsp_count_ws0", 64'(rc0.size()), 64'd4);
    check("latency_ws0", 64'(rc0[0] - a0), 64'd1);
    for (int i = 1; i < 4; i++) check("period_ws0", 64'(rc0[i] - rc0[i-1]), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
